nibble_serial_adder: RTL and testbench

Multi-cycle wide adder that streams WIDTH-bit operands through one 4-bit ripple adder (`fa4bit`), one nibble per clock, LSB nibble first. A registered carry links each nibble to the next. The block sits between an operand producer and a result consumer, with a valid/ready handshake on each side. It trades latency for area: one 4-bit adder serves any multiple-of-4 width.

---
 rtl/nibble_serial_adder_pkg.sv | 18 +
 rtl/nibble_serial_adder_fa4bit.sv | 24 ++
 rtl/nibble_serial_adder.sv | 125 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and helpers for the nibble-serial adder: FSM state encoding,
// nibble width and the nibble-counter width function.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that indexes nibbles 0..nibbles-1.
  function automatic int cnt_width(input int nibbles);
    return $clog2(nibbles);
  endfunction

endpackage

// File: rtl/nibble_serial_adder_fa4bit.sv
// fa4bit: 4-bit ripple-carry adder, the single nibble datapath of the
// nibble-serial adder.
module fa4bit
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per clock through a single fa4bit,
// LSB first. Define NIBBLE_SERIAL_ADDER_SUB_EN to add the 'sub' port (a - b).
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = cnt_width(NIBBLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
  end

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sr, b_sr, res_sr;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               accept, last;
  logic [WIDTH-1:0]   b_load;
  logic               carry_load;
  logic [NIBBLE_W-1:0] nib_sum;
  logic               nib_cout;
  logic [WIDTH-1:0]   res_next;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  // Subtraction as a + ~b + 1: invert B once at load, force the carry-in.
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  fa4bit u_fa4bit (
    .a    (a_sr[NIBBLE_W-1:0]),
    .b    (b_sr[NIBBLE_W-1:0]),
    .cin  (carry),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  assign res_next = {nib_sum, res_sr[WIDTH-1:NIBBLE_W]};

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST_CNT) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b_load;
      carry <= carry_load;
      cnt   <= '0;
    end else if (state_q == RUN) begin
      a_sr   <= a_sr >> NIBBLE_W;
      b_sr   <= b_sr >> NIBBLE_W;
      res_sr <= res_next;
      carry  <= nib_cout;
      cnt    <= cnt + CNT_W'(1);
      if (last) begin
        sum  <= res_next;
        cout <= nib_cout;
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16): a scoreboard queue
// holds expected results pushed at accept and popped at completion.
module tb_nibble_serial_adder;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a, b;
  logic          cin;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   edge_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic c, input logic s);
    exp_t e;
    logic [W:0] full;
    if (s) begin
      e.s = av - bv;
      e.c = (av >= bv);
    end else begin
      full = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, c};
      e.s  = full[W-1:0];
      e.c  = full[W];
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one operation from IDLE; returns #1 after the accept edge.
  task automatic accept_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic c, input logic s, output int acc_edge);
    sb.push_back(model(av, bv, c, s));
    in_valid = 1'b1;
    a = av; b = bv; cin = c; sub = s;
    step();
    acc_edge = edge_cnt;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      step();
      cyc++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #12;
    n_checks++;
    if ({in_ready, out_valid, cout, sum} !== {1'b1, 1'b0, 1'b0, 16'h0000})
      $display("FAIL reset_during: rdy/vld/cout/sum=%b/%b/%b/%h required 1/0/0/0000",
               in_ready, out_valid, cout, sum);
    else n_pass++;
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({in_ready, out_valid, cout, sum} !== {1'b1, 1'b0, 1'b0, 16'h0000})
      $display("FAIL reset_after: rdy/vld/cout/sum=%b/%b/%b/%h required 1/0/0/0000",
               in_ready, out_valid, cout, sum);
    else n_pass++;
  endtask

  task automatic test_overflow();
    int   acc, cyc;
    exp_t e;
    accept_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, acc);
    wait_done(cyc);
    n_checks++;
    if (cyc !== 4) $display("FAIL ovf_latency: got %0d cycles required 4", cyc);
    else n_pass++;
    e = sb.pop_front();
    n_checks++;
    if ({cout, sum} !== {e.c, e.s})
      $display("FAIL ovf_result: got %b/%h required %b/%h", cout, sum, e.c, e.s);
    else n_pass++;
    handshake();
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL ovf_return_idle: rdy/vld=%b/%b required 1/0", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_basic();
    int   acc, cyc;
    logic rdy_seen;
    exp_t e;
    accept_op(16'h1234, 16'h4321, 1'b1, 1'b0, acc);
    rdy_seen = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      rdy_seen |= in_ready;
      step();
      cyc++;
    end
    for (int i = 0; i < 2; i++) begin
      rdy_seen |= in_ready;
      step();
    end
    n_checks++;
    if (rdy_seen !== 1'b0 || !out_valid)
      $display("FAIL basic_in_ready_low: in_ready seen=%b out_valid=%b required 0/1",
               rdy_seen, out_valid);
    else n_pass++;
    e = sb.pop_front();
    n_checks++;
    if ({cout, sum} !== {e.c, e.s})
      $display("FAIL basic_result: got %b/%h required %b/%h", cout, sum, e.c, e.s);
    else n_pass++;
    handshake();
  endtask

  task automatic test_hold();
    int   acc1, acc2, cyc;
    logic bad;
    exp_t e;
    accept_op(16'h8001, 16'h8000, 1'b0, 1'b0, acc1);
    wait_done(cyc);
    e = sb.pop_front();
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      a = W'($urandom); b = W'($urandom);
      step();
      if ({cout, sum} !== {e.c, e.s} || !out_valid || in_ready) bad = 1'b1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (bad) $display("FAIL hold_stable: got %b/%h vld=%b rdy=%b required %b/%h 1 0",
                      cout, sum, out_valid, in_ready, e.c, e.s);
    else n_pass++;
    handshake();
    n_checks++;
    if (!in_ready) $display("FAIL hold_release: in_ready=%b required 1", in_ready);
    else n_pass++;
    accept_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, acc2);
    n_checks++;
    if (acc2 - acc1 < 6)
      $display("FAIL hold_accept_gap: got %0d required >=6", acc2 - acc1);
    else n_pass++;
    wait_done(cyc);
    e = sb.pop_front();
    n_checks++;
    if ({cout, sum} !== {e.c, e.s})
      $display("FAIL hold_next_result: got %b/%h required %b/%h", cout, sum, e.c, e.s);
    else n_pass++;
    handshake();
  endtask

  task automatic test_reset_mid();
    int   acc, cyc;
    exp_t e;
    accept_op(16'h1111, 16'h2222, 1'b0, 1'b0, acc);
    step();
    step();
    rst_n = 1'b0;
    sb.delete();
    #1;
    n_checks++;
    if ({out_valid, cout, sum} !== {1'b0, 1'b0, 16'h0000})
      $display("FAIL rstmid_clear: vld/cout/sum=%b/%b/%h required 0/0/0000",
               out_valid, cout, sum);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_checks++;
    if (!in_ready) $display("FAIL rstmid_idle: in_ready=%b required 1", in_ready);
    else n_pass++;
    accept_op(16'h00FF, 16'h0001, 1'b0, 1'b0, acc);
    wait_done(cyc);
    e = sb.pop_front();
    n_checks++;
    if ({cout, sum} !== {e.c, e.s} || cyc !== 4)
      $display("FAIL rstmid_next: got %b/%h in %0d required %b/%h in 4",
               cout, sum, cyc, e.c, e.s);
    else n_pass++;
    handshake();
  endtask

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    logic [W-1:0] av_t[4] = '{16'h0007, 16'h0005, 16'h0007, 16'h0005};
    logic [W-1:0] bv_t[4] = '{16'h0005, 16'h0007, 16'h0005, 16'h0007};
    logic         c_t[4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
    int   acc, cyc;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      accept_op(av_t[i], bv_t[i], c_t[i], 1'b1, acc);
      wait_done(cyc);
      e = sb.pop_front();
      n_checks++;
      if ({cout, sum} !== {e.c, e.s})
        $display("FAIL sub_%0d: got %b/%h required %b/%h", i, cout, sum, e.c, e.s);
      else n_pass++;
      handshake();
    end
    sub = 1'b0;
  endtask
`endif

  task automatic test_back_to_back();
    int           prev_acc, acc, cyc;
    logic         bad;
    logic [W-1:0] prev_sum;
    exp_t         e;
    prev_acc = -1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int n = 0; n < 5; n++) begin
      cyc = 0;
      while (!in_ready && cyc < 50) begin
        step();
        cyc++;
      end
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      sb.push_back(model(a, b, cin, 1'b0));
      step();
      acc = edge_cnt;
      if (prev_acc >= 0) begin
        n_checks++;
        if (acc - prev_acc !== 6)
          $display("FAIL b2b_gap_%0d: got %0d required 6", n, acc - prev_acc);
        else n_pass++;
      end
      prev_acc = acc;
      prev_sum = sum;
      bad = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 50) begin
        if (sum !== prev_sum) bad = 1'b1;
        step();
        cyc++;
      end
      e = sb.pop_front();
      n_checks++;
      if (bad || {cout, sum} !== {e.c, e.s})
        $display("FAIL b2b_result_%0d: got %b/%h early_change=%b required %b/%h",
                 n, cout, sum, bad, e.c, e.s);
      else n_pass++;
    end
    in_valid  = 1'b0;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_basic();
    test_hold();
    test_reset_mid();
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
